// File: rtl/comm_sequencer.sv
// Command/response sequencer for the UART path: collects a variable number of operands,
// strobes memory, waits a fixed delay and returns an ACK/NACK code over ready/valid.
module comm_sequencer #(
  parameter int OPD_MAX      = 4,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int OPD_TIMEOUT  = 200,
  parameter int DELAY_CYCLES = 8,
  localparam int OPD_W       = $clog2(OPD_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             connect,
  input  logic             disconnect,
  input  logic             rx_valid,
  input  logic             cmd_valid,
  input  logic [OPD_W-1:0] cmd_opds,
  output logic             opd_strobe,
  output logic [OPD_W-1:0] opd_idx,
  output logic             mem_en,
  output logic             resp_valid,
  output logic [1:0]       resp_code,
  input  logic             resp_ready,
  output logic             linked,
  output logic             link_lost,
  output logic [2:0]       state_o
);

  localparam int TMR_MAX =
    (IDLE_TIMEOUT > OPD_TIMEOUT)
      ? ((IDLE_TIMEOUT > DELAY_CYCLES) ? IDLE_TIMEOUT : DELAY_CYCLES)
      : ((OPD_TIMEOUT > DELAY_CYCLES) ? OPD_TIMEOUT : DELAY_CYCLES);
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [1:0] RESP_ACK         = 2'b00;
  localparam logic [1:0] RESP_NACK_CMD    = 2'b01;
  localparam logic [1:0] RESP_NACK_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_DISCONNECT = 3'd0,
    ST_IDLE       = 3'd1,
    ST_GET_OPDS   = 3'd2,
    ST_MEM        = 3'd3,
    ST_DELAY      = 3'd4,
    ST_RESP       = 3'd5
  } state_e;

  state_e           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [OPD_W-1:0] opd_cnt_q;
  logic [OPD_W-1:0] opd_target_q;
  logic [1:0]       code_q;
  logic             link_lost_q;

  logic idleExpired;
  logic opdExpired;
  logic delayExpired;
  logic opdsInRange;
  logic lastOperand;

  // Expiry fires in the Nth cycle of a state, so the move happens on the edge ending it.
  assign idleExpired  = (timer_q == TMR_W'(IDLE_TIMEOUT - 1));
  assign opdExpired   = (timer_q == TMR_W'(OPD_TIMEOUT - 1));
  assign delayExpired = (timer_q == TMR_W'(DELAY_CYCLES - 1));
  assign opdsInRange  = (cmd_opds != '0) && (cmd_opds <= OPD_W'(OPD_MAX));
  assign lastOperand  = (opd_cnt_q == (opd_target_q - OPD_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DISCONNECT;
      timer_q      <= '0;
      opd_cnt_q    <= '0;
      opd_target_q <= '0;
      code_q       <= RESP_ACK;
      link_lost_q  <= 1'b0;
    end else begin
      link_lost_q <= 1'b0;
      timer_q     <= timer_q + TMR_W'(1);
      if (disconnect && (state_q != ST_DISCONNECT)) begin
        state_q <= ST_DISCONNECT;
        timer_q <= '0;
      end else begin
        case (state_q)
          ST_DISCONNECT: begin
            if (connect) begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          end
          ST_IDLE: begin
            if (rx_valid) begin
              timer_q <= '0;
              if (cmd_valid && opdsInRange) begin
                state_q      <= ST_GET_OPDS;
                opd_target_q <= cmd_opds;
                opd_cnt_q    <= '0;
              end else if (cmd_valid && (cmd_opds == '0)) begin
                state_q <= ST_MEM;
              end else begin
                state_q <= ST_RESP;
                code_q  <= RESP_NACK_CMD;
              end
            end else if (idleExpired) begin
              state_q     <= ST_DISCONNECT;
              timer_q     <= '0;
              link_lost_q <= 1'b1;
            end
          end
          // A byte arriving in the expiry cycle still counts as an operand.
          ST_GET_OPDS: begin
            if (rx_valid) begin
              opd_cnt_q <= opd_cnt_q + OPD_W'(1);
              timer_q   <= '0;
              if (lastOperand) begin
                state_q <= ST_MEM;
              end
            end else if (opdExpired) begin
              state_q <= ST_RESP;
              code_q  <= RESP_NACK_TIMEOUT;
              timer_q <= '0;
            end
          end
          ST_MEM: begin
            state_q <= ST_DELAY;
            timer_q <= '0;
          end
          ST_DELAY: begin
            if (delayExpired) begin
              state_q <= ST_RESP;
              code_q  <= RESP_ACK;
              timer_q <= '0;
            end
          end
          ST_RESP: begin
            if (resp_ready) begin
              state_q <= ST_IDLE;
              timer_q <= '0;
            end
          end
          default: begin
            state_q <= ST_DISCONNECT;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  assign opd_strobe = (state_q == ST_GET_OPDS) && rx_valid && !disconnect;
  assign opd_idx    = opd_cnt_q;
  assign mem_en     = (state_q == ST_MEM);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_code  = code_q;
  assign linked     = (state_q != ST_DISCONNECT);
  assign link_lost  = link_lost_q;
  assign state_o    = state_q;

endmodule

// File: doc/comm_sequencer.md
# comm_sequencer

Parametrised command/response sequencer for the UART processing path. It sits between the receiver/command decoder and the memory/transmitter side and supersedes the fixed three-timer controller. It has an internal timeout counter and an operand counter, so no external timers or timer mux are needed. It supports a variable operand count per command, a per-byte operand timeout, a configurable memory delay, an idle-disconnect watchdog, and a ready/valid response channel that carries ACK/NACK codes.

## Interface
- `OPD_MAX`, 4: maximum operands per command (≥1).
- `IDLE_TIMEOUT`, 1000: cycles in IDLE without traffic before dropping the link (≥2).
- `OPD_TIMEOUT`, 200: maximum cycles between operand bytes (≥2).
- `DELAY_CYCLES`, 8: cycles spent in DELAY after the memory strobe (≥1).
- Derived: `OPD_W = $clog2(OPD_MAX+1)`; `TMR_W` = bits for max(IDLE_TIMEOUT, OPD_TIMEOUT, DELAY_CYCLES).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous reset, active-low.
- `connect` in 1: level, request to enter link.
- `disconnect` in 1: level, request to leave link.
- `rx_valid` in 1: one-cycle strobe, byte received.
- `cmd_valid` in 1: decoder flag; the current byte is a legal command (qualified by `rx_valid` in IDLE).
- `cmd_opds` in OPD_W: operand count of the current command.
- `opd_strobe` out 1: current `rx_valid` byte is an operand.
- `opd_idx` out OPD_W: index of that operand (0-based).
- `mem_en` out 1: one-cycle memory access strobe.
- `resp_valid` out 1: response pending.
- `resp_code` out 2: 00 ACK, 01 NACK_CMD, 10 NACK_TIMEOUT.
- `resp_ready` in 1: transmitter accepts the response.
- `linked` out 1: high in every state except DISCONNECT.
- `link_lost` out 1: one-cycle pulse on idle-watchdog expiry.
- `state_o` out 3: current state, for debug.

## Operation
- States: DISCONNECT(0), IDLE(1), GET_OPDS(2), MEM(3), DELAY(4), RESP(5). Undefined encodings go to DISCONNECT.
- Timer: a single counter, cleared on every state entry. It increments each cycle the state is held. An expiry is flagged when count = N−1 for the state's limit N, so the transition occurs on the edge ending the Nth cycle in the state.
- Global priority: `disconnect` high in any state other than DISCONNECT → DISCONNECT next cycle. Any pending response is dropped and `resp_valid` falls. This overrides all other events.
- DISCONNECT: `connect` high → IDLE.
- IDLE, first matching condition wins:
  - `rx_valid` & `cmd_valid` & 1 ≤ `cmd_opds` ≤ OPD_MAX → GET_OPDS. Latch `cmd_opds` into `opd_target`; clear the operand counter.
  - `rx_valid` & `cmd_valid` & `cmd_opds` = 0 → MEM.
  - `rx_valid` otherwise (invalid command, or `cmd_opds` > OPD_MAX) → RESP with code NACK_CMD.
  - Timer expiry at IDLE_TIMEOUT → DISCONNECT, with `link_lost` = 1 for that transition cycle.
- GET_OPDS:
  - `rx_valid` → `opd_strobe` = 1 and `opd_idx` = counter; the counter increments and the timer clears.
  - When the operand just accepted has index `opd_target`−1 → MEM.
  - Timer expiry at OPD_TIMEOUT with no `rx_valid` → RESP with code NACK_TIMEOUT.
  - `rx_valid` wins over expiry in the same cycle.
- MEM: `mem_en` = 1 for exactly one cycle → DELAY.
- DELAY: expiry at DELAY_CYCLES → RESP with code ACK. `rx_valid` is ignored.
- RESP: `resp_valid` = 1 and `resp_code` is stable. If `resp_valid` & `resp_ready` → IDLE. `rx_valid` is ignored.
- `opd_strobe` is combinational: state = GET_OPDS & `rx_valid` & !`disconnect`.
- All other outputs decode from registered state, counters and the code register.

## Timing
- Reset (`rst_n` = 0 at `clk` edge):
  - state = DISCONNECT; timer, operand counter, `opd_target` and code register = 0.
  - Outputs: `linked` = 0, `mem_en` = 0, `resp_valid` = 0, `resp_code` = 00, `link_lost` = 0, `opd_idx` = 0, `state_o` = 0.
  - Reset mid-transaction aborts with no response.
- `connect` to `linked` high: 1 cycle.
- From the last operand's `rx_valid` edge: `mem_en` high in the next cycle. DELAY occupies DELAY_CYCLES cycles. `resp_valid` rises DELAY_CYCLES+1 cycles after `mem_en`.
- `resp_valid` holds until a handshake. IDLE is entered the cycle after the handshake, and a new command is accepted from then on.
- `rx_valid` arriving in the handshake cycle itself is dropped.
- `link_lost` and `mem_en` never last more than one cycle.

## Test plan
Parameters for all scenarios: OPD_MAX=4, IDLE_TIMEOUT=100, OPD_TIMEOUT=20, DELAY_CYCLES=8.
- Reset, then `connect`: `linked` = 1 after 1 cycle. Then a command with `cmd_opds` = 3 and bytes every 5 cycles: `opd_idx` 0,1,2 strobed, `mem_en` one cycle after the 3rd byte, ACK after 8 DELAY cycles. `resp_ready` tied high → back in IDLE.
- `cmd_valid` = 0, and separately `cmd_opds` = 5: `resp_code` = 01 on the next cycle, with no `mem_en`.
- `cmd_opds` = 2, one operand, then silence: `resp_code` = 10 exactly 20 cycles after that operand. Repeat with the 2nd byte at cycle 20 → accepted, `mem_en` follows.
- IDLE with no traffic for 100 cycles: `link_lost` pulses once, `linked` = 0. Repeat with `rx_valid` at cycle 99 → no drop.
- `cmd_opds` = 0: `mem_en` in the next cycle. `resp_ready` held low for 10 cycles: `resp_valid` and `resp_code` stable, IDLE one cycle after `resp_ready`.
- `disconnect` asserted in GET_OPDS, in DELAY, and in RESP: DISCONNECT next cycle, `resp_valid` = 0. `rst_n` = 0 in DELAY: all outputs at reset values.
